// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between an execute-stage port (A)
// and a branch-compare port (B), with registered operands and per-port response channels.
module alu_share_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              a_req_valid_i,
    output logic              a_req_ready_o,
    input  logic [CTRL_W-1:0] a_ctrl_i,
    input  logic [XLEN-1:0]   a_op1_i,
    input  logic [XLEN-1:0]   a_op2_i,
    output logic              a_rsp_valid_o,
    input  logic              a_rsp_ready_i,
    output logic [XLEN-1:0]   a_rsp_data_o,
    output logic              a_rsp_zero_o,

    input  logic              b_req_valid_i,
    output logic              b_req_ready_o,
    input  logic [CTRL_W-1:0] b_ctrl_i,
    input  logic [XLEN-1:0]   b_op1_i,
    input  logic [XLEN-1:0]   b_op2_i,
    output logic              b_rsp_valid_o,
    input  logic              b_rsp_ready_i,
    output logic [XLEN-1:0]   b_rsp_data_o,
    output logic              b_rsp_zero_o,

    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [XLEN-1:0]   alu_op1_o,
    output logic [XLEN-1:0]   alu_op2_o,
    input  logic [XLEN-1:0]   alu_res_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;  // 0 = A, 1 = B
    logic               prio_q, prio_d;    // 0 = A, 1 = B
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [XLEN-1:0]    op1_q, op1_d;
    logic [XLEN-1:0]    op2_q, op2_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               zero_q, zero_d;

    logic grant_a, grant_b, rsp_hs;

    // Grants are gated by reset so ready reads 0 while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n_i && state_q == StIdle) begin
            grant_a = a_req_valid_i && (!b_req_valid_i || !prio_q);
            grant_b = b_req_valid_i && (!a_req_valid_i || prio_q);
        end
        rsp_hs = (state_q == StResp) && (owner_q ? b_rsp_ready_i : a_rsp_ready_i);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (grant_a) begin
                    ctrl_d  = a_ctrl_i;
                    op1_d   = a_op1_i;
                    op2_d   = a_op2_i;
                    owner_d = 1'b0;
                    state_d = StExec;
                end else if (grant_b) begin
                    ctrl_d  = b_ctrl_i;
                    op1_d   = b_op1_i;
                    op2_d   = b_op2_i;
                    owner_d = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d   = alu_res_i;
                zero_d  = (alu_res_i == '0);
                state_d = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    prio_d  = ~owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        a_req_ready_o = grant_a;
        b_req_ready_o = grant_b;
        busy_o        = (state_q != StIdle);

        alu_ctrl_o = (state_q == StExec) ? ctrl_q : '0;
        alu_op1_o  = (state_q == StExec) ? op1_q : '0;
        alu_op2_o  = (state_q == StExec) ? op2_q : '0;

        a_rsp_valid_o = (state_q == StResp) && !owner_q;
        b_rsp_valid_o = (state_q == StResp) && owner_q;
        a_rsp_data_o  = a_rsp_valid_o ? res_q : '0;
        a_rsp_zero_o  = a_rsp_valid_o && zero_q;
        b_rsp_data_o  = b_rsp_valid_o ? res_q : '0;
        b_rsp_zero_o  = b_rsp_valid_o && zero_q;
    end

endmodule
